mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 4:1 channel mux. Steps sel[1:0] through channels 0..3,

---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/mux_scan_dwell_cnt.sv | 38 +++
 rtl/mux_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the scanned 4:1 mux sampler.
package mux_scan_pkg;

    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } scan_state_e;

    // Even parity bit: set when the vector has an odd number of ones.
    function automatic logic even_par(input logic [NUM_CH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable down-counter that times the settle period on each channel.
// done_o is high whenever the count has reached zero.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               done_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 channel mux: steps sel through 0..3, lets each
// channel settle for DWELL_CYC cycles, samples mux_out, and offers the
// assembled 4-bit snapshot on a valid/ready interface.
// Optional feature: define MUX_SCAN_PARITY_EN to add the registered snap_par
// output (even parity of snap, valid with snap_valid).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYC    = 2,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] snap,
    output logic              snap_valid,
    input  logic              snap_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              snap_par
`endif
);

    // The counter is loaded with DWELL_CYC-1 so that SETTLE spans exactly
    // DWELL_CYC cycles (it leaves on the cycle the count reads zero).
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC - 1);

    scan_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] snap_q, snap_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] cap_vec;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_done;

    mux_scan_dwell_cnt u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (DWELL_LOAD),
        .done_o     (cnt_done)
    );

    // Shadow with the current channel's bit replaced by the live mux output;
    // this is what gets stored in CAPTURE (and published on the last channel).
    always_comb begin
        cap_vec         = shadow_q;
        cap_vec[sel_q]  = mux_out;
    end

    // Next-state and datapath-update logic for the scan FSM.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        valid_d  = valid_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (start) begin
                    state_d  = SETTLE;
                    cnt_load = 1'b1;
                end
            end

            SETTLE: begin
                if (cnt_done) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            CAPTURE: begin
                shadow_d = cap_vec;
                if (sel_q != LAST_SEL) begin
                    sel_d    = sel_q + SEL_W'(1);
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end else begin
                    snap_d  = cap_vec;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // sel stays on the last channel until the consumer takes the
                // snapshot, so it never wraps in the middle of a scan.
                if (valid_q && snap_ready) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (AUTO_RESTART) begin
                        state_d  = SETTLE;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, channel select, shadow and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            snap_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic par_q, par_d;

    // Parity is computed from the value being published so it lands in the
    // same cycle as the new snapshot.
    always_comb begin
        par_d = par_q;
        if ((state_q == CAPTURE) && (sel_q == LAST_SEL)) begin
            par_d = even_par(cap_vec);
        end
    end

    // Parity register, updated together with snap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign snap_par = par_q;
`endif

    assign sel        = sel_q;
    assign busy       = (state_q != IDLE);
    assign snap       = snap_q;
    assign snap_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL_CYC=2 one-shot, DWELL_CYC=1
// auto-restart), a time-based reference model, a vector table and directed
// corner-case sequences.
module tb_mux_scan_ctrl;

    localparam int D0 = 2;
    localparam int D1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1, ready0, ready1;
    logic [3:0] in0, in1;
    logic       mux0, mux1;
    logic [1:0] sel0, sel1;
    logic       busy0, busy1, vld0, vld1;
    logic [3:0] snap0, snap1;
`ifdef MUX_SCAN_PARITY_EN
    logic       par0, par1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mux0 = in0[sel0];
    assign mux1 = in1[sel1];

    mux_scan_ctrl #(.DWELL_CYC(D0), .AUTO_RESTART(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .mux_out    (mux0),
        .sel        (sel0),
        .busy       (busy0),
        .snap       (snap0),
        .snap_valid (vld0),
        .snap_ready (ready0)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .snap_par   (par0)
`endif
    );

    mux_scan_ctrl #(.DWELL_CYC(D1), .AUTO_RESTART(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .mux_out    (mux1),
        .sel        (sel1),
        .busy       (busy1),
        .snap       (snap1),
        .snap_valid (vld1),
        .snap_ready (ready1)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .snap_par   (par1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: a scan occupies 4*(D+1) edges after the start edge;
    // channel i is sampled on edge (i+1)*(D+1) and sel is elapsed/(D+1).
    int         m_mode [2];   // 0 idle, 1 scanning, 2 holding
    int         m_el   [2];   // edges elapsed since scan start
    logic [3:0] m_bits [2];
    logic [3:0] m_snap [2];

    task automatic model_step(input int i, input int d, input bit ar,
                              input logic st, input logic rdy, input logic [3:0] iv);
        int ch;
        case (m_mode[i])
            0: if (st) begin
                m_mode[i] = 1;
                m_el[i]   = 0;
            end
            1: begin
                m_el[i] = m_el[i] + 1;
                if (m_el[i] % (d + 1) == 0) begin
                    ch = m_el[i] / (d + 1) - 1;
                    m_bits[i][ch] = iv[ch];
                    if (ch == 3) begin
                        m_snap[i] = m_bits[i];
                        m_mode[i] = 2;
                    end
                end
            end
            default: if (rdy) begin
                if (ar) begin
                    m_mode[i] = 1;
                    m_el[i]   = 0;
                end else begin
                    m_mode[i] = 0;
                end
            end
        endcase
    endtask

    function automatic int m_sel(input int i, input int d);
        if (m_mode[i] == 1) return m_el[i] / (d + 1);
        if (m_mode[i] == 2) return 3;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0;
                m_el[i]   = 0;
                m_bits[i] = '0;
                m_snap[i] = '0;
            end
        end else begin
            model_step(0, D0, 1'b0, start0, ready0, in0);
            model_step(1, D1, 1'b1, start1, ready1, in1);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m0_sel",  32'(sel0),  32'(m_sel(0, D0)));
            chk("m0_busy", 32'(busy0), 32'(m_mode[0] != 0));
            chk("m0_vld",  32'(vld0),  32'(m_mode[0] == 2));
            chk("m0_snap", 32'(snap0), 32'(m_snap[0]));
            chk("m1_sel",  32'(sel1),  32'(m_sel(1, D1)));
            chk("m1_busy", 32'(busy1), 32'(m_mode[1] != 0));
            chk("m1_vld",  32'(vld1),  32'(m_mode[1] == 2));
            chk("m1_snap", 32'(snap1), 32'(m_snap[1]));
`ifdef MUX_SCAN_PARITY_EN
            chk("m0_par",  32'(par0),  32'(^m_snap[0]));
            chk("m1_par",  32'(par1),  32'(^m_snap[1]));
`endif
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_vld0(input int limit);
        int n = 0;
        while (vld0 !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_vld0_timeout", 32'(vld0), 32'(1));
    endtask

    typedef struct {
        logic [3:0] in_vec;
        int         hold_cyc;
        logic [3:0] exp_snap;
        logic       exp_par;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [3:0] held;

        tbl[0] = '{4'b0000, 0, 4'b0000, 1'b0};
        tbl[1] = '{4'b1111, 2, 4'b1111, 1'b0};
        tbl[2] = '{4'b0111, 1, 4'b0111, 1'b1};
        tbl[3] = '{4'b0011, 3, 4'b0011, 1'b0};
        tbl[4] = '{4'b1000, 0, 4'b1000, 1'b1};
        tbl[5] = '{4'b0101, 4, 4'b0101, 1'b0};
        tbl[6] = '{4'b1110, 1, 4'b1110, 1'b1};
        tbl[7] = '{4'b1010, 2, 4'b1010, 1'b0};

        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b0; ready1 = 1'b0;
        in0    = 4'b0; in1    = 4'b0;

        // Reset values
        #1;
        chk("rst_sel",  32'(sel0),  32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_vld",  32'(vld0),  32'(0));
        chk("rst_snap", 32'(snap0), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: sel walk, latency 12, zero-cycle handshake
        in0    = 4'b1010;
        ready0 = 1'b1;
        pulse_start0();
        for (int k = 0; k < 12; k++) begin
            chk("t1_sel",  32'(sel0),  32'(k / 3));
            chk("t1_vld",  32'(vld0),  32'(0));
            chk("t1_busy", 32'(busy0), 32'(1));
            @(negedge clk);
        end
        chk("t1_vld12",  32'(vld0),  32'(1));
        chk("t1_snap12", 32'(snap0), 32'(4'b1010));
        @(negedge clk);
        chk("t1_busy_drop", 32'(busy0), 32'(0));
        chk("t1_vld_drop",  32'(vld0),  32'(0));
        chk("t1_sel_back",  32'(sel0),  32'(0));

        // Test 2: back-pressure for 5 cycles
        in0    = 4'b0110;
        ready0 = 1'b0;
        pulse_start0();
        wait_vld0(30);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_hold_vld",  32'(vld0),  32'(1));
            chk("t2_hold_snap", 32'(snap0), 32'(4'b0110));
            chk("t2_hold_sel",  32'(sel0),  32'(3));
        end
        ready0 = 1'b1;
        @(negedge clk);
        chk("t2_vld_after", 32'(vld0), 32'(0));
        ready0 = 1'b0;

        // Test 3: start during channel-1 settle is ignored
        in0    = 4'b1100;
        ready0 = 1'b1;
        pulse_start0();
        cnt = 0;
        while (sel0 != 2'd1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("t3_reach_ch1", 32'(sel0), 32'(1));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (vld0 === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("t3_one_snap", 32'(cnt),   32'(1));
        chk("t3_snap",     32'(snap0), 32'(4'b1100));
        chk("t3_idle",     32'(busy0), 32'(0));
        pulse_start0();
        chk("t3_restart_sel",  32'(sel0),  32'(0));
        chk("t3_restart_busy", 32'(busy0), 32'(1));
        wait_vld0(30);
        @(negedge clk);

        // Test 4: async reset in CAPTURE of channel 2
        ready0 = 1'b0;
        in0    = 4'b1111;
        pulse_start0();
        repeat (8) @(negedge clk);
        chk("t4_pre_sel", 32'(sel0), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_sel",  32'(sel0),  32'(0));
        chk("t4_rst_busy", 32'(busy0), 32'(0));
        chk("t4_rst_vld",  32'(vld0),  32'(0));
        chk("t4_rst_snap", 32'(snap0), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ready0 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vld0 === 1'b1 || busy0 === 1'b1) cnt++;
        end
        chk("t4_no_vld", 32'(cnt), 32'(0));

        // Table-driven vectors
        for (int t = 0; t < 8; t++) begin
            in0    = tbl[t].in_vec;
            ready0 = 1'b0;
            pulse_start0();
            wait_vld0(30);
            chk("tbl_snap", 32'(snap0), 32'(tbl[t].exp_snap));
`ifdef MUX_SCAN_PARITY_EN
            chk("tbl_par",  32'(par0),  32'(tbl[t].exp_par));
`endif
            held = snap0;
            repeat (tbl[t].hold_cyc) @(negedge clk);
            chk("tbl_held", 32'(snap0), 32'(held));
            ready0 = 1'b1;
            @(negedge clk);
            chk("tbl_vld_clr", 32'(vld0), 32'(0));
            ready0 = 1'b0;
        end

        // Test 5: auto-restart, back-to-back snapshots
        in1    = 4'b0110;
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        while (vld1 !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5_latency", 32'(cnt),   32'(8));
        chk("t5_snap_a",  32'(snap1), 32'(4'b0110));
        in1 = 4'b1001;
        cnt = 0;
        do begin
            @(negedge clk);
            chk("t5_busy", 32'(busy1), 32'(1));
            cnt++;
        end while (vld1 !== 1'b1 && cnt < 20);
        chk("t5_vld_b",  32'(vld1),  32'(1));
        chk("t5_snap_b", 32'(snap1), 32'(4'b1001));

        // Randomized traffic, checked by the model, with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in0    = 4'($urandom);
            in1    = 4'($urandom);
            start0 = ($urandom_range(0, 3) == 0);
            start1 = ($urandom_range(0, 3) == 0);
            ready0 = 1'($urandom);
            ready1 = 1'($urandom);
            if (c == 1500) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
